// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_oversample
//  Purpose  : 16x oversampling UART receiver with 3-sample majority vote.
//             Delivers each byte as a one-cycle valid strobe and flags
//             framing errors. Default format is 8N1.
//  Option   : define UART_RX_PARITY_EN to expect one parity bit (8E1/8O1,
//             selected by PARITY_ODD) and drive parity_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversample #(
  parameter int FCLK       = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  // Oversampling tick divider, rounded to nearest integer.
  localparam int C_DIV   = (FCLK + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int C_DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(C_DIV - 1);

  // Sample indices inside one bit period (sample 0 is the first tick).
  localparam logic [3:0] C_SMP_A    = 4'd7;
  localparam logic [3:0] C_SMP_B    = 4'd8;
  localparam logic [3:0] C_SMP_DEC  = 4'd9;
  localparam logic [3:0] C_SMP_LAST = 4'(OVS - 1);

  // Receiver states.
  localparam logic [2:0] C_ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] C_ST_IDLE      = 3'd1;
  localparam logic [2:0] C_ST_START     = 3'd2;
  localparam logic [2:0] C_ST_DATA      = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] C_ST_PARITY    = 3'd4;
`endif
  localparam logic [2:0] C_ST_STOP      = 3'd5;

  // Synchronizer and edge history.
  logic       rx_meta_q;
  logic       rx_s_q;
  logic       rx_prev_q;
  logic [1:0] fill_q;

  // Timing counters.
  logic [C_DIV_W-1:0] div_q;
  logic [3:0]         sample_q;
  logic [2:0]         bit_q;

  // Majority-vote history and data shift register.
  logic       s7_q;
  logic       s8_q;
  logic [7:0] shift_q;

  // FSM and registered outputs.
  logic [2:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  // Combinational helpers.
  logic w_tick;
  logic w_dec;
  logic w_wrap;
  logic w_maj;
  logic w_start_edge;
  logic w_par_bad;

  assign w_tick       = (div_q == C_DIV_LAST);
  assign w_dec        = w_tick && (sample_q == C_SMP_DEC);
  assign w_wrap       = w_tick && (sample_q == C_SMP_LAST);
  assign w_maj        = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign w_start_edge = (state_q == C_ST_IDLE) && rx_prev_q && !rx_s_q;

  // Two-flop synchronizer, previous-sample register and refill tracker.
  // The synchronizer flops reset to 1, so right after reset rx_s does not
  // yet reflect the pin; fill_q[1] marks when it does, which keeps a line
  // held low through reset from looking idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= 2'b00;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  // Tick divider and sample counter, realigned on every start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      sample_q <= '0;
    end else if (w_start_edge) begin
      div_q    <= '0;
      sample_q <= '0;
    end else if (w_tick) begin
      div_q    <= '0;
      sample_q <= sample_q + 4'd1;
    end else begin
      div_q    <= div_q + 1'b1;
    end
  end

  // Majority-vote samples, data shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      if (w_tick && (sample_q == C_SMP_A)) s7_q <= rx_s_q;
      if (w_tick && (sample_q == C_SMP_B)) s8_q <= rx_s_q;
      if (w_start_edge) begin
        bit_q <= '0;
      end else if (state_q == C_ST_DATA) begin
        if (w_dec)  shift_q <= {w_maj, shift_q[7:1]};
        if (w_wrap) bit_q   <= bit_q + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic perr_q, perr_d;

  // Capture the voted parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if ((state_q == C_ST_PARITY) && w_dec) begin
      par_q <= w_maj;
    end
  end

  assign w_par_bad = par_q ^ ((^shift_q) ^ PARITY_ODD);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign w_par_bad         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_ST_WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_WAIT_IDLE: begin
        if (fill_q[1] && rx_s_q) state_d = C_ST_IDLE;
      end
      C_ST_IDLE: begin
        if (w_start_edge) state_d = C_ST_START;
      end
      C_ST_START: begin
        if (w_dec && w_maj) state_d = C_ST_IDLE;
        else if (w_wrap)    state_d = C_ST_DATA;
      end
      C_ST_DATA: begin
        if (w_wrap && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = C_ST_PARITY;
`else
          state_d = C_ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      C_ST_PARITY: begin
        if (w_wrap) state_d = C_ST_STOP;
      end
`endif
      C_ST_STOP: begin
        // Leave at the decision sample so a new start edge can be caught
        // in the second half of the stop bit.
        if (w_dec) state_d = w_maj ? C_ST_IDLE : C_ST_WAIT_IDLE;
      end
      default: state_d = C_ST_WAIT_IDLE;
    endcase
  end

  // FSM output logic: strobes are decided at the stop-bit decision sample.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
`endif
    if ((state_q == C_ST_STOP) && w_dec) begin
      if (w_maj) begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = w_par_bad;
`endif
      end else begin
        ferr_d  = 1'b1;
      end
    end
    busy_o = (state_q == C_ST_START) || (state_q == C_ST_DATA) ||
`ifdef UART_RX_PARITY_EN
             (state_q == C_ST_PARITY) ||
`endif
             (state_q == C_ST_STOP);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = w_par_bad;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_oversample
//  Purpose  : Self-checking bench for uart_rx_oversample. Runs the receiver
//             at a fast line rate (4 clocks per oversample tick) so many
//             frames fit in a short run. Honours UART_RX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversample;

  localparam int FCLK   = 100000000;
  localparam int BAUD   = 1562500;
  localparam int OVS    = 16;
  localparam bit PODD   = 1'b0;
  localparam int TB_DIV = (FCLK + (BAUD * OVS) / 2) / (BAUD * OVS);
`ifdef UART_RX_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif
  // pin edge -> valid: 2 sync cycles + start/data(/parity) bits + 10 ticks into stop
  localparam int LAT_CLK = 2 + (9 + PBITS) * OVS * TB_DIV + 10 * TB_DIV;
  // sender bit time slightly longer than the receiver's 640 ns bit
  localparam int BIT_NS  = 642;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, busy_o;

  uart_rx_oversample #(
    .FCLK(FCLK), .BAUD(BAUD), .OVS(OVS), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
    .parity_err_o(parity_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_valid;
    logic [7:0] data;
    logic       perr;
    time        t;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic       exp_valid;
    logic       exp_perr;
  } vec_t;

  ev_t  evq[$];
  ev_t  mon_ev;
  int   both_hi     = 0;
  int   orphan_perr = 0;
  int   checks      = 0;
  int   errors      = 0;
  time  t_fall;
  logic [7:0] mdl_last;

  // Event monitor: records every strobe seen on the outputs.
  always @(negedge clk) begin
    if (valid_o === 1'b1 || frame_err_o === 1'b1) begin
      mon_ev.is_valid = (valid_o === 1'b1);
      mon_ev.data     = data_o;
      mon_ev.perr     = parity_err_o;
      mon_ev.t        = $time;
      evq.push_back(mon_ev);
    end
    if (valid_o === 1'b1 && frame_err_o === 1'b1) both_hi++;
    if (parity_err_o === 1'b1 && valid_o !== 1'b1) orphan_perr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference rule for the parity flag of a delivered byte.
  function automatic logic exp_perr_of(input logic [7:0] b, input logic par);
    logic want;
    want = (^b) ^ PODD;
    return (PBITS != 0) ? (par != want) : 1'b0;
  endfunction

  // Drive one frame; a 0 stop bit may be stretched low by hold_ns.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int hold_ns);
    @(negedge clk);
    t_fall = $time;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    if (PBITS != 0) begin
      rx = par;
      #(BIT_NS);
    end
    rx = stop;
    #(BIT_NS);
    if (hold_ns > 0) #(hold_ns);
    rx = 1'b1;
  endtask

  task automatic expect_valid(input string name, input logic [7:0] d, input logic pe, output time t_ev);
    ev_t e;
    t_ev = 0;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL %s_present actual=no_strobe required=valid", name);
      return;
    end
    e = evq.pop_front();
    t_ev = e.t;
    chk({name, "_kind"}, {31'd0, e.is_valid}, 32'd1);
    chk({name, "_data"}, {24'd0, e.data}, {24'd0, d});
    chk({name, "_perr"}, {31'd0, e.perr}, {31'd0, pe});
    mdl_last = d;
  endtask

  task automatic expect_ferr(input string name);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL %s_present actual=no_strobe required=frame_err", name);
      return;
    end
    e = evq.pop_front();
    chk({name, "_kind"}, {31'd0, e.is_valid}, 32'd0);
  endtask

  task automatic expect_none(input string name);
    chk({name, "_no_strobe"}, evq.size(), 32'd0);
    evq.delete();
  endtask

  task automatic idle_checks(input string name);
    chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({name, "_hold"}, {24'd0, data_o}, {24'd0, mdl_last});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    mdl_last = 8'h00;
    evq.delete();
  endtask

  // Watchdog.
  initial begin
    #(5ms);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[6];
    logic [7:0] str[9];
    time        t_ev;
    logic [7:0] rb;
    logic       rstop, rpar;

    vt[0] = '{8'h54, 1'b1, ^8'h54, 1'b1, 1'b0};
    vt[1] = '{8'hA5, 1'b1, ^8'hA5, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1'b0,   1'b1, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1'b0,   1'b1, 1'b0};
    vt[4] = '{8'h3C, 1'b0, ^8'h3C, 1'b0, 1'b0};
    vt[5] = '{8'h03, 1'b1, 1'b1,   1'b1, (PBITS != 0)};
    str   = '{8'h54, 8'h65, 8'h73, 8'h74, 8'h20, 8'h65, 8'h63, 8'h68, 8'h6F};
    mdl_last = 8'h00;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_data",  {24'd0, data_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    chk("rst_perr",  {31'd0, parity_err_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].data, vt[i].stop, vt[i].par, 0);
      #(BIT_NS);
      if (vt[i].exp_valid) begin
        expect_valid($sformatf("vec%0d", i), vt[i].data, vt[i].exp_perr, t_ev);
        if (i == 0) chk_range("latency_ns", longint'(t_ev - t_fall),
                              longint'(10 * LAT_CLK - 5), longint'(10 * LAT_CLK + 15));
      end else begin
        expect_ferr($sformatf("vec%0d", i));
      end
      expect_none($sformatf("vec%0d_extra", i));
      idle_checks($sformatf("vec%0d", i));
    end

    // Back-to-back string
    for (int i = 0; i < 9; i++) send_frame(str[i], 1'b1, ^str[i] ^ PODD, 0);
    #(BIT_NS);
    chk("str_count", evq.size(), 32'd9);
    for (int i = 0; i < 9; i++) expect_valid($sformatf("str%0d", i), str[i], 1'b0, t_ev);
    idle_checks("str");

    // Short glitch is a false start
    @(negedge clk);
    rx = 1'b0;
    #200;
    rx = 1'b1;
    #(2 * BIT_NS);
    expect_none("glitch");
    idle_checks("glitch");
    send_frame(8'hA5, 1'b1, ^8'hA5 ^ PODD, 0);
    #(BIT_NS);
    expect_valid("after_glitch", 8'hA5, 1'b0, t_ev);

    // Stop bit low, then line held low
    send_frame(8'h3C, 1'b0, ^8'h3C ^ PODD, 1500);
    #(2 * BIT_NS);
    expect_ferr("ferr_hold");
    expect_none("ferr_hold_extra");
    idle_checks("ferr_hold");
    send_frame(8'h3C, 1'b1, ^8'h3C ^ PODD, 0);
    #(BIT_NS);
    expect_valid("ferr_resend", 8'h3C, 1'b0, t_ev);

    // Line held low through and after reset
    @(negedge clk);
    rx = 1'b0;
    do_reset(20);
    #4000;
    expect_none("held_low");
    chk("held_low_busy", {31'd0, busy_o}, 32'd0);
    rx = 1'b1;
    #(2 * BIT_NS);
    send_frame(8'h01, 1'b1, ^8'h01 ^ PODD, 0);
    #(BIT_NS);
    expect_valid("held_low_then", 8'h01, 1'b0, t_ev);

    // Reset in bit 4 of a frame (0xF0: line stays high after bit 3)
    @(negedge clk);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2);
    chk("midrst_busy_before", {31'd0, busy_o}, 32'd1);
    do_reset(3);
    chk("midrst_data", {24'd0, data_o}, 32'd0);
    #(6 * BIT_NS);
    expect_none("midrst");
    idle_checks("midrst");
    send_frame(8'hFF, 1'b1, ^8'hFF ^ PODD, 0);
    #(BIT_NS);
    expect_valid("midrst_then", 8'hFF, 1'b0, t_ev);

    // Randomized frames against the reference rules
    for (int n = 0; n < 10; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rpar  = 1'($urandom_range(0, 1));
      send_frame(rb, rstop, rpar, 0);
      #(BIT_NS + 2 * $urandom_range(0, 200));
      if (rstop) expect_valid($sformatf("rnd%0d", n), rb, exp_perr_of(rb, rpar), t_ev);
      else       expect_ferr($sformatf("rnd%0d", n));
      expect_none($sformatf("rnd%0d_extra", n));
      idle_checks($sformatf("rnd%0d", n));
    end

`ifdef UART_RX_PARITY_EN
    // Parity-specific pair
    send_frame(8'h03, 1'b1, 1'b0, 0);
    #(BIT_NS);
    expect_valid("par_good", 8'h03, 1'b0, t_ev);
    send_frame(8'h03, 1'b1, 1'b1, 0);
    #(BIT_NS);
    expect_valid("par_bad", 8'h03, 1'b1, t_ev);
`endif

    chk("both_strobes", both_hi, 32'd0);
    chk("orphan_perr", orphan_perr, 32'd0);
    chk("leftover", evq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
